// File: rtl/slave_internal_response_wr_arbiter_if.sv
// Bus bundle for the slave B-channel response arbiter.
// It carries the two internal response sources (error and posted) and the
// AXI B channel. The arbiter connects through the 'slave' modport. The
// surrounding logic (sources plus the AXI master side) uses 'master'.
interface slave_internal_response_wr_arbiter_if #(
    parameter int ID_WIDTH   = 4,
    parameter int RESP_WIDTH = 2
);
    logic                  err_valid;
    logic                  err_ready;
    logic [ID_WIDTH-1:0]   err_bid;
    logic [RESP_WIDTH-1:0] err_bresp;

    logic                  pst_valid;
    logic                  pst_ready;
    logic [ID_WIDTH-1:0]   pst_bid;
    logic [RESP_WIDTH-1:0] pst_bresp;

    logic                  BVALID;
    logic                  BREADY;
    logic [ID_WIDTH-1:0]   BID;
    logic [RESP_WIDTH-1:0] BRESP;

    logic                  last_grant;

    modport slave (
        input  err_valid, err_bid, err_bresp,
        output err_ready,
        input  pst_valid, pst_bid, pst_bresp,
        output pst_ready,
        output BVALID, BID, BRESP,
        input  BREADY,
        output last_grant
    );

    modport master (
        output err_valid, err_bid, err_bresp,
        input  err_ready,
        output pst_valid, pst_bid, pst_bresp,
        input  pst_ready,
        input  BVALID, BID, BRESP,
        output BREADY,
        input  last_grant
    );
endinterface

// File: rtl/slave_internal_response_wr_arbiter.sv
// slave_internal_response_wr_arbiter
// This block buffers write responses from the error responder (source 0)
// and from the posted-write completion path (source 1). Each source has its
// own small FIFO. The block drives the AXI B channel from one registered
// output stage.
//
// Arbitration is round-robin by default. When SLAVE_B_ERR_PRIORITY_EN is
// defined, the error FIFO has strict priority whenever it is non-empty.
//
// The ID_WIDTH and RESP_WIDTH parameters must match the ones used for the
// connected interface instance.
module slave_internal_response_wr_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int RESP_WIDTH = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic arst,
    slave_internal_response_wr_arbiter_if.slave bus
);
    localparam int DW = ID_WIDTH + RESP_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Index 0 is the error source. Index 1 is the posted source.
    logic [1:0]    push_valid;
    logic [DW-1:0] push_data [2];
    logic [1:0]    pop;
    logic [1:0]    fifo_full;
    logic [1:0]    fifo_empty;
    logic [DW-1:0] head_data [2];

    assign push_valid   = {bus.pst_valid, bus.err_valid};
    assign push_data[0] = {bus.err_bid, bus.err_bresp};
    assign push_data[1] = {bus.pst_bid, bus.pst_bresp};

    // Ready is taken only from the registered count. A full FIFO refuses a
    // push even in a cycle where it pops.
    assign bus.err_ready = !fifo_full[0];
    assign bus.pst_ready = !fifo_full[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DW-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          push;

            assign push           = push_valid[gi] && !fifo_full[gi];
            assign fifo_full[gi]  = (count_reg == CW'(FIFO_DEPTH));
            assign fifo_empty[gi] = (count_reg == '0);
            assign head_data[gi]  = mem[rd_ptr_reg];

            // Storage write. There is no reset because contents are only
            // read when the count says an entry is valid.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= push_data[gi];
                end
            end

            // Pointers and occupancy. Push and pop in the same cycle leave
            // the count unchanged.
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    logic                  bvalid_reg;
    logic [ID_WIDTH-1:0]   bid_reg;
    logic [RESP_WIDTH-1:0] bresp_reg;
    logic                  last_grant_reg;

    logic                  grant_pst_next;
    logic                  load_next;
    logic [DW-1:0]         selected_data;

    // Choose which source the next load takes from.
    always_comb begin
        grant_pst_next = 1'b0;
`ifdef SLAVE_B_ERR_PRIORITY_EN
        grant_pst_next = fifo_empty[0];
`else
        if (fifo_empty[0]) begin
            grant_pst_next = 1'b1;
        end else if (fifo_empty[1]) begin
            grant_pst_next = 1'b0;
        end else begin
            grant_pst_next = !last_grant_reg;
        end
`endif
    end

    // The output stage loads when it is free or being consumed, and only if
    // some FIFO holds an entry.
    assign load_next     = (!bvalid_reg || bus.BREADY) && !(fifo_empty[0] && fifo_empty[1]);
    assign pop           = {load_next && grant_pst_next, load_next && !grant_pst_next};
    assign selected_data = grant_pst_next ? head_data[1] : head_data[0];

    // Registered B channel. BID and BRESP hold while BVALID waits for BREADY.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bvalid_reg     <= 1'b0;
            bid_reg        <= '0;
            bresp_reg      <= '0;
            last_grant_reg <= 1'b1;
        end else if (load_next) begin
            bvalid_reg     <= 1'b1;
            bid_reg        <= selected_data[DW-1:RESP_WIDTH];
            bresp_reg      <= selected_data[RESP_WIDTH-1:0];
            last_grant_reg <= grant_pst_next;
        end else if (bus.BREADY) begin
            bvalid_reg     <= 1'b0;
        end
    end

    assign bus.BVALID     = bvalid_reg;
    assign bus.BID        = bid_reg;
    assign bus.BRESP      = bresp_reg;
    assign bus.last_grant = last_grant_reg;
endmodule

// File: tb/tb_slave_internal_response_wr_arbiter.sv
// Testbench for slave_internal_response_wr_arbiter.
// A queue-based reference model of the two sources and the B channel is
// compared with the DUT on every falling edge. Directed sequences also pin
// literal values. Honours SLAVE_B_ERR_PRIORITY_EN when it is defined.
module tb_slave_internal_response_wr_arbiter;
    localparam int IDW   = 4;
    localparam int RW    = 2;
    localparam int DEPTH = 2;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    slave_internal_response_wr_arbiter_if #(.ID_WIDTH(IDW), .RESP_WIDTH(RW)) bif ();

    slave_internal_response_wr_arbiter #(
        .ID_WIDTH(IDW), .RESP_WIDTH(RW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .arst(arst),
        .bus (bif)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, plus the B-channel register.
    logic [IDW+RW-1:0] m_eq[$];
    logic [IDW+RW-1:0] m_pq[$];
    logic              m_bv;
    logic [IDW-1:0]    m_bid;
    logic [RW-1:0]     m_bresp;
    logic              m_lg;

    // Model step: decide acceptance from pre-edge fullness, pop at most one
    // entry into the output, then append the accepted pushes.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_eq.delete();
            m_pq.delete();
            m_bv    = 1'b0;
            m_bid   = '0;
            m_bresp = '0;
            m_lg    = 1'b1;
        end else begin
            bit acc_e, acc_p, have_e, have_p, take_p;
            logic [IDW+RW-1:0] item;
            acc_e  = bif.err_valid && (m_eq.size() < DEPTH);
            acc_p  = bif.pst_valid && (m_pq.size() < DEPTH);
            have_e = m_eq.size() > 0;
            have_p = m_pq.size() > 0;
            if ((!m_bv || bif.BREADY) && (have_e || have_p)) begin
`ifdef SLAVE_B_ERR_PRIORITY_EN
                take_p = !have_e;
`else
                take_p = have_p && (!have_e || (m_lg == 1'b0));
`endif
                if (take_p) item = m_pq.pop_front();
                else        item = m_eq.pop_front();
                m_bv              = 1'b1;
                {m_bid, m_bresp}  = item;
                m_lg              = take_p;
            end else if (bif.BREADY) begin
                m_bv = 1'b0;
            end
            if (acc_e) m_eq.push_back({bif.err_bid, bif.err_bresp});
            if (acc_p) m_pq.push_back({bif.pst_bid, bif.pst_bresp});
        end
    end

    // Compare the DUT against the model once per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!arst) begin
            chk("bvalid", bif.BVALID, m_bv);
            if (m_bv) begin
                chk("bid", bif.BID, m_bid);
                chk("bresp", bif.BRESP, m_bresp);
            end
            chk("last_grant", bif.last_grant, m_lg);
            chk("err_ready", bif.err_ready, m_eq.size() < DEPTH);
            chk("pst_ready", bif.pst_ready, m_pq.size() < DEPTH);
        end
    end

    // Record completed B transfers and accepted pushes.
    logic [IDW-1:0] xfer_q[$];
    int             n_xfer = 0;
    int             n_push = 0;
    always @(posedge clk) begin
        if (!arst) begin
            if (bif.BVALID && bif.BREADY) begin
                xfer_q.push_back(bif.BID);
                n_xfer++;
            end
            if (bif.err_valid && bif.err_ready) n_push++;
            if (bif.pst_valid && bif.pst_ready) n_push++;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bif.err_valid = 1'b0;
        bif.pst_valid = 1'b0;
    endtask

    task automatic drive_err(input int bid, input int bresp);
        bif.err_valid = 1'b1;
        bif.err_bid   = IDW'(bid);
        bif.err_bresp = RW'(bresp);
    endtask

    task automatic drive_pst(input int bid, input int bresp);
        bif.pst_valid = 1'b1;
        bif.pst_bid   = IDW'(bid);
        bif.pst_bresp = RW'(bresp);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_bvalid"}, bif.BVALID, 0);
        chk({tag, "_bid"}, bif.BID, 0);
        chk({tag, "_bresp"}, bif.BRESP, 0);
        chk({tag, "_last_grant"}, bif.last_grant, 1);
        chk({tag, "_err_ready"}, bif.err_ready, 1);
        chk({tag, "_pst_ready"}, bif.pst_ready, 1);
    endtask

    task automatic apply_reset();
        idle();
        arst = 1'b1;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        idle();
        bif.err_bid   = '0;
        bif.err_bresp = '0;
        bif.pst_bid   = '0;
        bif.pst_bresp = '0;
        bif.BREADY    = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single error response. It shows on the B channel two cycles later, for one cycle.
        bif.BREADY = 1'b1;
        drive_err(3, 2);
        step();
        idle();
        chk("lat_c1_bvalid", bif.BVALID, 0);
        step();
        chk("lat_c2_bvalid", bif.BVALID, 1);
        chk("lat_c2_bid", bif.BID, 3);
        chk("lat_c2_bresp", bif.BRESP, 2);
        chk("lat_c2_last_grant", bif.last_grant, 0);
        step();
        chk("lat_c3_bvalid", bif.BVALID, 0);

        // Both sources present. Check the arbitration order.
        apply_reset();
        bif.BREADY = 1'b1;
        xfer_q.delete();
        drive_err(1, 0); drive_pst(5, 0);
        step();
        drive_err(2, 0); drive_pst(6, 0);
        step();
        idle();
        repeat (6) step();
        chk("arb_count", xfer_q.size(), 4);
`ifdef SLAVE_B_ERR_PRIORITY_EN
        chk("arb_0", xfer_q[0], 1); chk("arb_1", xfer_q[1], 2);
        chk("arb_2", xfer_q[2], 5); chk("arb_3", xfer_q[3], 6);
`else
        chk("arb_0", xfer_q[0], 1); chk("arb_1", xfer_q[1], 5);
        chk("arb_2", xfer_q[2], 2); chk("arb_3", xfer_q[3], 6);
`endif

        // Stall with BREADY low, fill the posted FIFO, then drain.
        apply_reset();
        bif.BREADY = 1'b0;
        drive_err(7, 1);
        step();
        idle();
        step();
        drive_pst(8, 0);
        step();
        drive_pst(9, 0);
        step();
        drive_pst(10, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_bvalid", bif.BVALID, 1);
            chk("stall_bid", bif.BID, 7);
            chk("stall_bresp", bif.BRESP, 1);
        end
        chk("stall_pst_ready", bif.pst_ready, 0);
        xfer_q.delete();
        bif.BREADY = 1'b1;
        // The FIFO is full and pops in this edge. The push is refused, so the count drops to 1.
        step();
        chk("fullpop_bid", bif.BID, 8);
        chk("fullpop_pst_ready", bif.pst_ready, 1);
        step();
        idle();
        repeat (4) step();
        chk("drain_count", xfer_q.size(), 4);
        chk("drain_0", xfer_q[0], 7); chk("drain_1", xfer_q[1], 8);
        chk("drain_2", xfer_q[2], 9); chk("drain_3", xfer_q[3], 10);

        // Asynchronous reset while both FIFOs are full and BVALID is high.
        apply_reset();
        bif.BREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_err(k + 1, k);
            drive_pst(k + 4, k);
            step();
        end
        idle();
        chk("prerst_bvalid", bif.BVALID, 1);
        chk("prerst_bid", bif.BID, 1);
        chk("prerst_err_ready", bif.err_ready, 0);
        chk("prerst_pst_ready", bif.pst_ready, 0);
        arst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        arst = 1'b0;
        bif.BREADY = 1'b1;
        xfer_q.delete();
        repeat (5) step();
        chk("postrst_xfers", xfer_q.size(), 0);
        chk("postrst_bvalid", bif.BVALID, 0);

        // Random stress run. The model checks order, single issue and BVALID stability.
        apply_reset();
        n_xfer = 0;
        n_push = 0;
        for (int c = 0; c < 10000; c++) begin
            bif.err_valid = 1'($urandom_range(0, 1));
            bif.err_bid   = IDW'($urandom);
            bif.err_bresp = RW'($urandom);
            bif.pst_valid = 1'($urandom_range(0, 1));
            bif.pst_bid   = IDW'($urandom);
            bif.pst_bresp = RW'($urandom);
            bif.BREADY    = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        bif.BREADY = 1'b1;
        repeat (8) step();
        chk("stress_all_issued", n_xfer, n_push);
        chk("stress_bvalid_idle", bif.BVALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
